// File: rtl/free_list.sv
// -----------------------------------------------------------------------------
// free_list
//
// Physical-register free list for the out-of-order rename stage. Sits upstream
// of the map table and supplies the next free physical register tag. The list
// is a circular FIFO of PR tags with first-word-fall-through output.
//
// After reset the list holds the tags NUM_LR..NUM_PR-1. PRs 0..NUM_LR-1 are
// architecturally mapped at that point, so they are not free.
//
// Ports
//   clk            in   clock; all state changes on the rising edge
//   rst            in   asynchronous, active-high reset
//   RegDest        in   dispatching instruction writes rd (allocation request)
//   hazard_stall   in   dispatch is stalled; blocks allocation
//   retire         in   ROB head retires this cycle
//   RegDest_retire in   retiring instruction had an rd
//   PR_old_retire  in   previous mapping of the retiring rd; freed on retire
//   recover        in   ROB is walking back one entry this cycle
//   RegDest_ROB    in   flushed entry had an rd
//   p_rd_flush     in   PR allocated by the flushed entry; freed on recovery
//   p_rd_new       out  head-of-list PR tag, valid whenever empty = 0
//   empty          out  no free PR; dispatch must stall
//   free_cnt       out  number of free entries, 0..DEPTH
// -----------------------------------------------------------------------------
module free_list #(
    parameter int NUM_PR = 64,
    parameter int NUM_LR = 32,
    parameter int DEPTH  = NUM_PR - NUM_LR,
    parameter int TAG_W  = $clog2(NUM_PR),
    parameter int PTR_W  = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             RegDest,
    input  logic             hazard_stall,
    input  logic             retire,
    input  logic             RegDest_retire,
    input  logic [TAG_W-1:0] PR_old_retire,
    input  logic             recover,
    input  logic             RegDest_ROB,
    input  logic [TAG_W-1:0] p_rd_flush,
    output logic [TAG_W-1:0] p_rd_new,
    output logic             empty,
    output logic [TAG_W-1:0] free_cnt
);

    logic [TAG_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] head_q, head_d;
    logic [PTR_W-1:0] tail_q, tail_d;
    logic [TAG_W-1:0] count_q, count_d;

    logic             empty_s;
    logic             full_s;
    logic             pop_s;
    logic             push_req_s;
    logic             push_s;
    logic [TAG_W-1:0] push_data_s;

    // Outputs are driven only from registered state, so there is no
    // combinational path from any input to p_rd_new, empty or free_cnt.
    assign empty_s  = (count_q == {TAG_W{1'b0}});
    assign full_s   = (count_q == TAG_W'(DEPTH));
    assign p_rd_new = mem_q[head_q];
    assign empty    = empty_s;
    assign free_cnt = count_q;

    // Allocation/free decisions and next-state pointers and count.
    always_comb begin
        // Allocation is blocked during a ROB walk and whenever the list is
        // empty in the current state (a same-cycle push cannot be bypassed).
        pop_s = RegDest & ~hazard_stall & ~recover & ~empty_s;

        // Recovery owns the single write port; the ROB never retires during
        // a walk, so retire is ignored while recover is high.
        if (recover) begin
            push_req_s  = RegDest_ROB;
            push_data_s = p_rd_flush;
        end else begin
            push_req_s  = retire & RegDest_retire;
            push_data_s = PR_old_retire;
        end

        // A push into a full list is only honoured when a pop frees a slot
        // in the same cycle; otherwise it is dropped and state is unchanged.
        push_s = push_req_s & (~full_s | pop_s);

        if (pop_s) begin
            head_d = head_q + PTR_W'(1);
        end else begin
            head_d = head_q;
        end

        if (push_s) begin
            tail_d = tail_q + PTR_W'(1);
        end else begin
            tail_d = tail_q;
        end

        if (push_s && !pop_s) begin
            count_d = count_q + TAG_W'(1);
        end else if (pop_s && !push_s) begin
            count_d = count_q - TAG_W'(1);
        end else begin
            count_d = count_q;
        end
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head_q  <= {PTR_W{1'b0}};
            tail_q  <= {PTR_W{1'b0}};
            count_q <= TAG_W'(DEPTH);
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Tag storage; reset loads the initially free tags NUM_LR..NUM_PR-1.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= TAG_W'(NUM_LR + i);
            end
        end else if (push_s) begin
            mem_q[tail_q] <= push_data_s;
        end
    end

endmodule

// File: tb/tb_free_list.sv
// -----------------------------------------------------------------------------
// tb_free_list
//
// Self-checking bench for free_list. A queue-based model of the free list is
// compared against the DUT on every falling edge, and directed scenarios add
// hand-computed literal expectations at key points.
// -----------------------------------------------------------------------------
module tb_free_list;

    logic       clk;
    logic       rst;
    logic       RegDest;
    logic       hazard_stall;
    logic       retire;
    logic       RegDest_retire;
    logic [5:0] PR_old_retire;
    logic       recover;
    logic       RegDest_ROB;
    logic [5:0] p_rd_flush;
    logic [5:0] p_rd_new;
    logic       empty;
    logic [5:0] free_cnt;

    int n_checks = 0;
    int n_pass   = 0;

    free_list dut (
        .clk            (clk),
        .rst            (rst),
        .RegDest        (RegDest),
        .hazard_stall   (hazard_stall),
        .retire         (retire),
        .RegDest_retire (RegDest_retire),
        .PR_old_retire  (PR_old_retire),
        .recover        (recover),
        .RegDest_ROB    (RegDest_ROB),
        .p_rd_flush     (p_rd_flush),
        .p_rd_new       (p_rd_new),
        .empty          (empty),
        .free_cnt       (free_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model: a plain queue of free tags ----------
    int unsigned m_q[$];

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_q.delete();
            for (int i = 0; i < 32; i++) m_q.push_back(32 + i);
        end else begin
            bit          do_pop;
            bit          do_push;
            int unsigned tag;
            do_pop = RegDest && !hazard_stall && !recover && (m_q.size() > 0);
            if (recover) begin
                do_push = RegDest_ROB;
                tag     = p_rd_flush;
            end else begin
                do_push = retire && RegDest_retire;
                tag     = PR_old_retire;
            end
            if (do_push) begin
                // Stimulus legality: never free PR 0, never overfill.
                chk("push_tag_nonzero", (tag != 0) ? 1 : 0, 1);
                chk("push_not_overfull", (m_q.size() < 32 || do_pop) ? 1 : 0, 1);
            end
            if (do_pop) void'(m_q.pop_front());
            if (do_push && m_q.size() < 32) m_q.push_back(tag);
        end
    end

    // Compare DUT against the model away from the active edge.
    always @(negedge clk) begin
        if (!rst) begin
            chk("model_free_cnt", free_cnt, m_q.size());
            chk("model_empty", empty, (m_q.size() == 0) ? 1 : 0);
            if (m_q.size() > 0) chk("model_p_rd_new", p_rd_new, m_q[0]);
        end
    end

    // ---------------- stimulus helpers ---------------------------------------
    task automatic step(input logic rd, input logic hs, input logic ret,
                        input logic rdr, input logic [5:0] pro, input logic rec,
                        input logic rdrob, input logic [5:0] fl);
        RegDest        = rd;
        hazard_stall   = hs;
        retire         = ret;
        RegDest_retire = rdr;
        PR_old_retire  = pro;
        recover        = rec;
        RegDest_ROB    = rdrob;
        p_rd_flush     = fl;
        @(posedge clk);
        #2;
    endtask

    task automatic do_pop();
        step(1'b1, 1'b0, 1'b0, 1'b0, 6'd0, 1'b0, 1'b0, 6'd0);
    endtask

    task automatic do_idle();
        step(1'b0, 1'b0, 1'b0, 1'b0, 6'd0, 1'b0, 1'b0, 6'd0);
    endtask

    task automatic do_retire(input logic [5:0] tag);
        step(1'b0, 1'b0, 1'b1, 1'b1, tag, 1'b0, 1'b0, 6'd0);
    endtask

    // ---------------- directed scenarios -------------------------------------
    initial begin
        rst = 1'b1;
        RegDest = 1'b0; hazard_stall = 1'b0; retire = 1'b0; RegDest_retire = 1'b0;
        PR_old_retire = 6'd0; recover = 1'b0; RegDest_ROB = 1'b0; p_rd_flush = 6'd0;
        repeat (2) @(posedge clk);
        #2;
        rst = 1'b0;

        // Reset state.
        chk("rst_p_rd_new", p_rd_new, 8'h20);
        chk("rst_empty", empty, 0);
        chk("rst_free_cnt", free_cnt, 32);

        // Three dispatches step the head.
        do_pop(); chk("disp1_p_rd_new", p_rd_new, 8'h21);
        do_pop(); chk("disp2_p_rd_new", p_rd_new, 8'h22);
        do_pop(); chk("disp3_p_rd_new", p_rd_new, 8'h23);
        chk("disp3_free_cnt", free_cnt, 29);

        // Stalled dispatch and dispatch without rd do not allocate.
        step(1'b1, 1'b1, 1'b0, 1'b0, 6'd0, 1'b0, 1'b0, 6'd0);
        step(1'b1, 1'b1, 1'b0, 1'b0, 6'd0, 1'b0, 1'b0, 6'd0);
        chk("stall_p_rd_new", p_rd_new, 8'h23);
        chk("stall_free_cnt", free_cnt, 29);
        do_idle();
        chk("nord_free_cnt", free_cnt, 29);

        // Drain to empty; further allocation requests change nothing.
        repeat (29) do_pop();
        chk("drain_empty", empty, 1);
        chk("drain_free_cnt", free_cnt, 0);
        do_pop();
        do_pop();
        chk("empty_hold_cnt", free_cnt, 0);

        // Push while empty with RegDest high: pop blocked, tag appears next.
        step(1'b1, 1'b0, 1'b1, 1'b1, 6'h05, 1'b0, 1'b0, 6'd0);
        chk("refill_p_rd_new", p_rd_new, 8'h05);
        chk("refill_empty", empty, 0);
        chk("refill_free_cnt", free_cnt, 1);

        // Recovery wins over retire and blocks allocation.
        step(1'b1, 1'b0, 1'b1, 1'b1, 6'h07, 1'b1, 1'b1, 6'h22);
        chk("recover_free_cnt", free_cnt, 2);
        chk("recover_p_rd_new", p_rd_new, 8'h05);
        do_pop();
        chk("recover_next_tag", p_rd_new, 8'h22);
        do_pop();
        chk("recover_drained", empty, 1);

        // Fill completely with tags 1..32.
        for (int i = 1; i <= 32; i++) do_retire(6'(i));
        chk("full_free_cnt", free_cnt, 32);
        chk("full_p_rd_new", p_rd_new, 8'h01);

        // Full with pop and push together: count stays at 32.
        step(1'b1, 1'b0, 1'b1, 1'b1, 6'h03, 1'b0, 1'b0, 6'd0);
        chk("fullpp_free_cnt", free_cnt, 32);
        chk("fullpp_p_rd_new", p_rd_new, 8'h02);
        repeat (31) do_pop();
        chk("wrap_p_rd_new", p_rd_new, 8'h03);
        chk("wrap_free_cnt", free_cnt, 1);

        // Mid-stream asynchronous reset between clock edges.
        do_pop();
        do_retire(6'h11);
        do_retire(6'h12);
        #1;
        rst = 1'b1;
        #1;
        chk("async_rst_p_rd_new", p_rd_new, 8'h20);
        chk("async_rst_free_cnt", free_cnt, 32);
        chk("async_rst_empty", empty, 0);
        rst = 1'b0;

        // Operation resumes normally after reset.
        do_pop();
        do_pop();
        chk("post_rst_p_rd_new", p_rd_new, 8'h22);
        do_retire(6'h09);
        chk("post_rst_free_cnt", free_cnt, 31);
        do_idle();
        do_idle();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/free_list.md
Name: free_list

Overview:
- Physical-register free list for the OoO rename stage; sits directly upstream of map_table.
- Supplies p_rd_new (next free physical register) to map_table on dispatch.
- Reclaims physical registers as instructions complete their lifecycle:
  - PR_old_rd is freed at ROB retire.
  - The speculative p_rd is returned during ROB-walk recovery.
- Circular FIFO of 6-bit PR tags with first-word-fall-through output.

Parameters:
- NUM_PR, 64, total physical registers; tags are 6 bits.
- NUM_LR, 32, logical registers; PRs 0..NUM_LR-1 are architecturally mapped at reset.
- DEPTH, 32, FIFO entries, equal to NUM_PR-NUM_LR.

Ports:
- clk  in  1  clock, all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- RegDest  in  1  dispatching instruction writes rd; requests allocation.
- hazard_stall  in  1  dispatch stalled this cycle; blocks allocation.
- retire  in  1  ROB head retires this cycle.
- RegDest_retire  in  1  retiring instruction had rd.
- PR_old_retire  in  6  previous mapping of retiring rd, to be freed.
- recover  in  1  ROB walking back one entry this cycle.
- RegDest_ROB  in  1  flushed entry had rd.
- p_rd_flush  in  6  PR allocated by the flushed entry, to be freed.
- p_rd_new  out  6  head-of-list PR tag, valid whenever empty=0.
- empty  out  1  no free PR; dispatch must stall.
- free_cnt  out  6  number of free entries, 0..32.

Behaviour:
- Storage and pointers:
  - mem[0..31] holds 6-bit tags; head and tail are 5-bit pointers that wrap modulo 32.
  - count is 6 bits, range 0..32.
- Reset (asynchronous, rst=1):
  - mem[i]=NUM_LR+i, i.e. 0x20..0x3F.
  - head=0, tail=0, count=32.
  - Outputs: p_rd_new=0x20, empty=0, free_cnt=32.
  - rst asserted mid-operation discards all in-flight state immediately, without waiting for a clock edge.
- Outputs:
  - p_rd_new=mem[head], combinational from registered state.
  - empty=(count==0).
  - free_cnt=count.
- Pop (alloc) = RegDest & ~hazard_stall & ~recover & ~empty.
  - On pop, head advances by 1 at the clock edge.
  - map_table captures p_rd_new in the same cycle that pop is high.
- Push source priority (at most one push per cycle):
  - If recover=1: push = RegDest_ROB, data = p_rd_flush. retire is ignored while recover=1, because the ROB never retires during a walk.
  - Else: push = retire & RegDest_retire, data = PR_old_retire.
  - On push: mem[tail]=data and tail advances by 1.
- Count update: +1 on push only, -1 on pop only, unchanged on push and pop together.
- Boundary conditions:
  - Empty with push in the same cycle: pop is blocked, because empty is evaluated on current state. The pushed tag becomes p_rd_new next cycle.
  - Full (count=32) with push and no pop: illegal. The push is dropped, state is unchanged, and the bench flags it as an error.
  - Full with push and pop in the same cycle: both take effect and count stays 32.
  - Wrap-around: pointers roll from 31 to 0 with no bubble.
  - PR 0 is never pushed: a tag of 0 on any push is illegal and is a bench assertion.
- Recovery: one flushed entry is returned per cycle. No allocation occurs while recover=1, even with RegDest=1.
- No combinational path exists from inputs to p_rd_new or empty. This guarantees zero-cycle bypass never occurs.

Test Plan:
- Reset release -> p_rd_new=0x20, empty=0, free_cnt=32; three dispatches with RegDest=1 -> p_rd_new steps 0x20, 0x21, 0x22, then 0x23; free_cnt=29.
- Dispatch RegDest=1 with hazard_stall=1 for 2 cycles -> p_rd_new stays 0x23, free_cnt unchanged; RegDest=0 dispatch -> no pop.
- 32 consecutive pops -> empty=1, free_cnt=0; further RegDest=1 -> no change. Then retire with PR_old_retire=0x05 -> next cycle p_rd_new=0x05, empty=0.
- recover=1, RegDest_ROB=1, p_rd_flush=0x22 concurrently with RegDest=1 and retire=1 (PR_old=0x07) -> only 0x22 pushed, no pop, free_cnt +1.
- From full: pop and retire (PR_old_retire=0x03) in the same cycle -> free_cnt stays 32; after 31 more pops p_rd_new=0x03, confirming tail wrap.
- Assert rst mid-stream between clock edges -> outputs immediately p_rd_new=0x20, free_cnt=32, empty=0.
